puf_query_sequencer: RTL

Multi-query PUF front end that expands one external challenge into NUM_SEGS sub-challenges and issues them to a PUF core over a request/acknowledge handshake. It assembles a RESPONSE_SIZE-bit response from SEG_SIZE-bit segments and unmasks that response with helper data. It sits between the system-level challenge interface (CHALLENGE / INPUT_READY / PUF_RESPONSE / DONE) and the raw PUF core. Compared with the previous single-shot wrapper, it adds two addressing modes, a core handshake timeout and error reporting.

---
 rtl/puf_query_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/puf_query_sequencer.sv
// Expands one challenge into NUM_SEGS core queries; DONE at cycle 2*NUM_SEGS with a zero-wait core.
// Each core wait cycle adds one cycle of latency; TIMEOUT REQ cycles without ACK abort with ERROR.
module puf_query_sequencer #(
    parameter int CHALLENGE_SIZE = 32,
    parameter int RESPONSE_SIZE  = 256,
    parameter int SEG_SIZE       = 32,
    parameter logic [CHALLENGE_SIZE-1:0] LFSR_TAPS = CHALLENGE_SIZE'(32'h80200003),
    parameter int TIMEOUT        = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHALLENGE_SIZE-1:0] CHALLENGE,
    input  logic                      INPUT_READY,
    input  logic                      MODE,
    input  logic [RESPONSE_SIZE-1:0]  HELPER_DATA,
    output logic                      CORE_REQ,
    output logic [CHALLENGE_SIZE-1:0] CORE_CHALLENGE,
    input  logic                      CORE_ACK,
    input  logic [SEG_SIZE-1:0]       CORE_RESP,
    output logic [RESPONSE_SIZE-1:0]  PUF_RESPONSE,
    output logic                      DONE,
    output logic                      BUSY,
    output logic                      ERROR
);
    localparam int NUM_SEGS = RESPONSE_SIZE / SEG_SIZE;
    localparam int IW       = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam int TW       = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic                                   r_mode;
    logic [NUM_SEGS-1:0][SEG_SIZE-1:0]      r_helper;
    logic [NUM_SEGS-1:0][SEG_SIZE-1:0]      r_resp;
    logic [CHALLENGE_SIZE-1:0]              r_addr;
    logic [IW-1:0]                          r_idx;
    logic [TW-1:0]                          r_timer;
    logic                                   r_req;
    logic                                   r_done;
    logic                                   r_busy;
    logic                                   r_err;
    logic                                   w_last;
    logic                                   w_timeout;
    logic                                   w_start;
    logic                                   w_ack;
    logic [CHALLENGE_SIZE-1:0]              w_seed;
    logic [CHALLENGE_SIZE-1:0]              w_addr_adv;
    logic [SEG_SIZE-1:0]                    w_seg;

    assign w_last    = (r_idx == IW'(NUM_SEGS - 1));
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));
    assign w_start   = (r_state == S_IDLE) && INPUT_READY;
    assign w_ack     = (r_state == S_ISSUE) && CORE_ACK;
    // An all-zero seed would lock the LFSR at zero forever.
    assign w_seed     = (MODE && (CHALLENGE == '0)) ? CHALLENGE_SIZE'(1) : CHALLENGE;
    assign w_addr_adv = r_mode ? ((r_addr >> 1) ^ (r_addr[0] ? LFSR_TAPS : '0))
                               : r_addr + CHALLENGE_SIZE'(1);
    assign w_seg      = CORE_RESP ^ r_helper[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (INPUT_READY) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (CORE_ACK)       w_state_nxt = w_last ? S_FINISH : S_GAP;
                else if (w_timeout) w_state_nxt = S_FAIL;
            end
            S_GAP:    w_state_nxt = S_ISSUE;
            S_FINISH: w_state_nxt = S_IDLE;
            S_FAIL:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mode   <= 1'b0;
            r_helper <= '0;
            r_resp   <= '0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode   <= MODE;
                r_helper <= HELPER_DATA;
                r_addr   <= w_seed;
                r_idx    <= '0;
                r_resp   <= '0;
                r_err    <= 1'b0;
            end
            if (w_ack) begin
                r_resp[r_idx] <= w_seg;
                if (!w_last) begin
                    r_idx  <= r_idx + IW'(1);
                    r_addr <= w_addr_adv;
                end
            end
            if (w_state_nxt == S_FAIL) begin
                r_resp <= '0;
                r_err  <= 1'b1;
            end
            // Clearing outside ISSUE makes every ISSUE entry start from zero.
            if (r_state != S_ISSUE) begin
                r_timer <= '0;
            end else if (!CORE_ACK) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_req  <= (w_state_nxt == S_ISSUE);
            r_done <= (w_state_nxt == S_FINISH) || (w_state_nxt == S_FAIL);
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign CORE_REQ       = r_req;
    assign CORE_CHALLENGE = r_addr;
    assign PUF_RESPONSE   = r_resp;
    assign DONE           = r_done;
    assign BUSY           = r_busy;
    assign ERROR          = r_err;
endmodule
